// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: state encodings, response codes and helpers
// shared by axi_mem_array and axi_mem_slave (no ports).
package axi_mem_pkg;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ADDR = 2'd1,
        W_DATA = 2'd2,
        W_RESP = 2'd3
    } wr_state_t;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    localparam int MAX_BEATS_DEF = 16;

    function automatic logic in_range(
        input int unsigned addr,
        input int unsigned depth
    );
        return addr < depth;
    endfunction

endpackage

// File: rtl/axi_mem_array.sv
// axi_mem_array: DEPTH x 8 byte storage, one sync write port and
// one sync read port; a read and write to the same byte in the same
// cycle returns the old byte.
// Ports: clk; wr_en/wr_addr/wr_data write port;
//        rd_en/rd_addr read request, rd_data registered read byte.
module axi_mem_array
    import axi_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: byte-wide burst memory slave with independent read
// (AR/R) and write (AW/W/B) channels.
// Ports: clk, rst (async, active-high);
//   AR: ARADDR ARLEN ARID ARVALID -> ARREADY
//   R : RVALID RDATA RRESP RLAST  <- RREADY
//   AW: AWADDR AWID AWVALID       -> AWREADY
//   W : WDATA WLAST WVALID        -> WREADY
//   B : BVALID BRESP={id,err}     <- BREADY
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [3:0]        ARID,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [7:0]        RDATA,
    output logic              RRESP,
    output logic              RLAST,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWID,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [7:0]        WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [4:0]        BRESP
);

    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam int BEAT_W = $clog2(MAX_BEATS + 1);

    function automatic logic beat_resp(
        input logic [ADDR_W-1:0] a
    );
        return in_range(32'(a), MEM_DEPTH)
            ? RESP_OKAY : RESP_SLVERR;
    endfunction

    // ---------------- read channel ----------------
    rd_state_t         r_state;
    rd_state_t         r_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_addr_inc;
    logic [3:0]        r_len;
    logic [3:0]        r_beat;
    logic [3:0]        r_id;
    logic              r_resp;
    logic              r_last;
    logic              r_adv;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;

    // Wraps mod 2^ADDR_W by construction.
    assign r_addr_inc = r_addr + ADDR_W'(1);

    assign r_adv = (r_state == R_DATA) && RREADY && !r_last;

    // The array is read one cycle ahead: the first byte in R_ADDR,
    // the next byte whenever a non-final beat is taken.
    assign rd_en   = (r_state == R_ADDR) || r_adv;
    assign rd_addr = (r_state == R_ADDR) ? r_addr : r_addr_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nxt;
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE: begin
                if (ARVALID) begin
                    r_state_nxt = R_ADDR;
                end
            end
            R_ADDR: r_state_nxt = R_DATA;
            R_DATA: begin
                if (RREADY && r_last) begin
                    r_state_nxt = R_IDLE;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        ARREADY = 1'b0;
        RVALID  = 1'b0;
        RDATA   = 8'h00;
        RRESP   = RESP_OKAY;
        RLAST   = 1'b0;
        case (r_state)
            R_ADDR: ARREADY = 1'b1;
            R_DATA: begin
                RVALID = 1'b1;
                RDATA  = (r_resp == RESP_SLVERR)
                    ? 8'h00 : rd_data;
                RRESP  = r_resp;
                RLAST  = r_last;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_id   <= '0;
            r_resp <= RESP_OKAY;
            r_last <= 1'b0;
        end else begin
            if (r_state == R_IDLE && ARVALID) begin
                r_addr <= ARADDR;
                r_len  <= ARLEN;
                r_id   <= ARID;
                r_beat <= '0;
            end
            if (r_state == R_ADDR) begin
                r_resp <= beat_resp(r_addr);
                r_last <= (r_len == 4'd0);
            end
            if (r_adv) begin
                r_addr <= r_addr_inc;
                r_beat <= r_beat + 4'd1;
                r_resp <= beat_resp(r_addr_inc);
                r_last <= ((r_beat + 4'd1) == r_len);
            end
        end
    end

    // ---------------- write channel ----------------
    wr_state_t         w_state;
    wr_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_addr;
    logic [3:0]        w_id;
    logic              w_err;
    logic [BEAT_W-1:0] w_beat;
    logic              w_fire;
    logic              w_room;
    logic              w_ok;
    logic              wr_en;

    assign w_fire = (w_state == W_DATA) && WVALID;
    // Beats past MAX_BEATS are still consumed, only discarded.
    assign w_room = 32'(w_beat) < MAX_BEATS;
    assign w_ok   = w_room && (beat_resp(w_addr) == RESP_OKAY);
    assign wr_en  = w_fire && w_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        unique case (w_state)
            W_IDLE: begin
                if (AWVALID) begin
                    w_state_nxt = W_ADDR;
                end
            end
            W_ADDR: w_state_nxt = W_DATA;
            W_DATA: begin
                if (WVALID && WLAST) begin
                    w_state_nxt = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_state_nxt = W_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        WREADY  = 1'b0;
        BVALID  = 1'b0;
        BRESP   = 5'd0;
        unique case (w_state)
            W_IDLE: ;
            W_ADDR: AWREADY = 1'b1;
            W_DATA: WREADY  = 1'b1;
            W_RESP: begin
                BVALID = 1'b1;
                BRESP  = {w_id, w_err};
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_addr <= '0;
            w_id   <= '0;
            w_err  <= 1'b0;
            w_beat <= '0;
        end else begin
            if (w_state == W_IDLE && AWVALID) begin
                w_addr <= AWADDR;
                w_id   <= AWID;
                w_err  <= 1'b0;
                w_beat <= '0;
            end
            if (w_fire) begin
                w_addr <= w_addr + ADDR_W'(1);
                if (w_room) begin
                    w_beat <= w_beat + BEAT_W'(1);
                end
                if (!w_ok) begin
                    w_err <= 1'b1;
                end
            end
        end
    end

    axi_mem_array #(
        .DEPTH (MEM_DEPTH),
        .AW    (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (w_addr[MEM_AW-1:0]),
        .wr_data (WDATA),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[MEM_AW-1:0]),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: randomized scoreboard bench for axi_mem_slave
// with a byte-array reference model (MEM_DEPTH = 128).
module tb_axi_mem_slave;

    localparam int DEPTH = 128;
    localparam int MAXB  = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] ARADDR = '0;
    logic [3:0] ARLEN = '0;
    logic [3:0] ARID = '0;
    logic       ARVALID = 1'b0;
    logic       ARREADY;
    logic       RVALID;
    logic       RREADY = 1'b0;
    logic [7:0] RDATA;
    logic       RRESP;
    logic       RLAST;
    logic [7:0] AWADDR = '0;
    logic [3:0] AWID = '0;
    logic       AWVALID = 1'b0;
    logic       AWREADY;
    logic [7:0] WDATA = '0;
    logic       WLAST = 1'b0;
    logic       WVALID = 1'b0;
    logic       WREADY;
    logic       BVALID;
    logic       BREADY = 1'b0;
    logic [4:0] BRESP;

    axi_mem_slave #(
        .ADDR_W    (8),
        .MEM_DEPTH (DEPTH),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ARADDR  (ARADDR),
        .ARLEN   (ARLEN),
        .ARID    (ARID),
        .ARVALID (ARVALID),
        .ARREADY (ARREADY),
        .RVALID  (RVALID),
        .RREADY  (RREADY),
        .RDATA   (RDATA),
        .RRESP   (RRESP),
        .RLAST   (RLAST),
        .AWADDR  (AWADDR),
        .AWID    (AWID),
        .AWVALID (AWVALID),
        .AWREADY (AWREADY),
        .WDATA   (WDATA),
        .WLAST   (WLAST),
        .WVALID  (WVALID),
        .WREADY  (WREADY),
        .BVALID  (BVALID),
        .BREADY  (BREADY),
        .BRESP   (BRESP)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       resp;
        logic       last;
    } rbeat_t;

    typedef logic [7:0] bytes_t [32];

    rbeat_t     rq [$];
    logic [4:0] bq [$];
    logic [7:0] ref_mem [256];
    int checks = 0;
    int errors = 0;
    int rmode  = 0;
    int bmode  = 0;

    task automatic check(input string name,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, got, exp);
        end
    endtask

    // Ready drivers: 0 = always 1, 1 = toggle, 2 = random.
    initial forever begin
        @(posedge clk);
        #1;
        case (rmode)
            0:       RREADY = 1'b1;
            1:       RREADY = !RREADY;
            default: RREADY = 1'($urandom_range(0, 1));
        endcase
        case (bmode)
            0:       BREADY = 1'b1;
            1:       BREADY = !BREADY;
            default: BREADY = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: compares every presented beat/response to the
    // scoreboard head; pops only on a completed handshake.
    initial forever begin
        rbeat_t     e;
        logic [4:0] b;
        @(negedge clk);
        if (RVALID) begin
            if (rq.size() == 0) begin
                check("r_unexpected", 32'(RVALID), 0);
            end else begin
                e = RREADY ? rq.pop_front() : rq[0];
                check(RREADY ? "r_beat" : "r_hold",
                      32'({RDATA, RRESP, RLAST}), 32'(e));
            end
        end
        if (ARREADY) check("ar_r_overlap", 32'(RVALID), 0);
        if (BVALID) begin
            if (bq.size() == 0) begin
                check("b_unexpected", 32'(BVALID), 0);
            end else begin
                b = BREADY ? bq.pop_front() : bq[0];
                check(BREADY ? "b_resp" : "b_hold",
                      32'(BRESP), 32'(b));
            end
        end
        if (AWREADY) check("aw_w_overlap", 32'(WREADY), 0);
    end

    task automatic ar_phase(input logic [7:0] addr,
                            input logic [3:0] len,
                            input logic [3:0] id);
        int     t;
        logic [7:0] a;
        rbeat_t e;
        for (int i = 0; i <= int'(len); i++) begin
            a = addr + 8'(i);
            e.last = (i == int'(len));
            if (int'(a) < DEPTH) begin
                e.data = ref_mem[a];
                e.resp = 1'b0;
            end else begin
                e.data = 8'h00;
                e.resp = 1'b1;
            end
            rq.push_back(e);
        end
        @(negedge clk);
        ARADDR  = addr;
        ARLEN   = len;
        ARID    = id;
        ARVALID = 1'b1;
        t = 0;
        while (!ARREADY && t < 16) begin
            @(negedge clk);
            t++;
        end
        ARVALID = 1'b0;
        check("ar_ready", 32'(ARREADY), 1);
        if (!ARREADY) begin
            rq.delete();
            return;
        end
        @(negedge clk);
        check("ar_pulse", 32'({ARREADY, RVALID}), 32'b01);
    endtask

    task automatic r_drain();
        int t = 0;
        while (rq.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (rq.size() > 0) begin
            check("r_drain", 32'(rq.size()), 0);
            rq.delete();
        end
    endtask

    task automatic do_read(input logic [7:0] addr,
                           input logic [3:0] len,
                           input logic [3:0] id);
        ar_phase(addr, len, id);
        r_drain();
    endtask

    task automatic aw_phase(input logic [7:0] addr,
                            input logic [3:0] id);
        int t;
        @(negedge clk);
        AWADDR  = addr;
        AWID    = id;
        AWVALID = 1'b1;
        t = 0;
        while (!AWREADY && t < 16) begin
            @(negedge clk);
            t++;
        end
        AWVALID = 1'b0;
        check("aw_ready", 32'(AWREADY), 1);
    endtask

    task automatic w_beat(input logic [7:0] d,
                          input logic last,
                          input logic gaps);
        int t;
        if (gaps && $urandom_range(0, 3) == 0) begin
            WVALID = 1'b0;
            @(negedge clk);
        end
        WVALID = 1'b1;
        WDATA  = d;
        WLAST  = last;
        t = 0;
        while (!WREADY && t < 16) begin
            @(negedge clk);
            t++;
        end
        if (!WREADY) check("w_ready", 32'(WREADY), 1);
        @(negedge clk);
        WVALID = 1'b0;
        WLAST  = 1'b0;
    endtask

    task automatic b_drain();
        int t = 0;
        while (bq.size() > 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (bq.size() > 0) begin
            check("b_drain", 32'(bq.size()), 0);
            bq.delete();
        end
    endtask

    task automatic do_write(input logic [7:0] addr,
                            input logic [3:0] id,
                            input int n,
                            input bytes_t dat,
                            input logic gaps);
        logic       err;
        logic [7:0] a;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            if (i >= MAXB || int'(a) >= DEPTH) err = 1'b1;
            else ref_mem[a] = dat[i];
        end
        bq.push_back({id, err});
        aw_phase(addr, id);
        for (int i = 0; i < n; i++) begin
            w_beat(dat[i], (i == n - 1), gaps);
        end
        b_drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bytes_t dat;
        bytes_t dat2;
        int     t;
        foreach (dat[i]) dat[i] = 8'($urandom);
        foreach (dat2[i]) dat2[i] = 8'($urandom);
        foreach (ref_mem[i]) ref_mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        check("reset_outputs",
              32'({ARREADY, RVALID, RDATA, RRESP, RLAST,
                   AWREADY, WREADY, BVALID, BRESP}), 0);
        rst = 1'b0;

        // Fill the implemented range so every byte is known.
        bmode = 2;
        for (int b = 0; b < DEPTH / 16; b++) begin
            foreach (dat[i]) dat[i] = 8'($urandom);
            do_write(8'(b * 16), 4'($urandom), 16, dat, 1'b1);
        end

        bmode = 0;
        rmode = 0;
        dat[0] = 8'hA0; dat[1] = 8'hA1;
        dat[2] = 8'hA2; dat[3] = 8'hA3;
        do_write(8'h10, 4'd5, 4, dat, 1'b0);
        do_read(8'h10, 4'd3, 4'd5);

        dat[0] = 8'h11; dat[1] = 8'h22;
        do_write(8'h20, 4'd9, 2, dat, 1'b0);
        do_read(8'h20, 4'd1, 4'd2);

        rmode = 1;
        do_read(8'h00, 4'd15, 4'd3);

        rmode = 0;
        do_read(8'h7F, 4'd1, 4'd4);
        dat[0] = 8'hEE;
        do_write(8'h80, 4'd3, 1, dat, 1'b0);
        do_read(8'h7E, 4'd3, 4'd4);

        // Overlong burst: 18 beats, only the first 16 land.
        bmode = 2;
        rmode = 2;
        foreach (dat[i]) dat[i] = 8'($urandom);
        do_write(8'h40, 4'd7, 18, dat, 1'b1);
        do_read(8'h40, 4'd15, 4'd1);
        do_read(8'h50, 4'd1, 4'd1);

        // AR and AW in the same cycle, disjoint regions.
        fork
            do_read(8'h00, 4'd7, 4'd2);
            do_write(8'h60, 4'd12, 4, dat2, 1'b1);
        join
        do_read(8'h60, 4'd3, 4'd2);

        // Address wrap through the out-of-range window.
        do_read(8'hFE, 4'd3, 4'd6);
        foreach (dat[i]) dat[i] = 8'($urandom);
        do_write(8'hFF, 4'd1, 3, dat, 1'b0);
        do_read(8'hFE, 4'd3, 4'd6);

        for (int k = 0; k < 24; k++) begin
            rmode = $urandom_range(0, 2);
            bmode = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) begin
                do_read(8'($urandom), 4'($urandom),
                        4'($urandom));
            end else begin
                foreach (dat[i]) dat[i] = 8'($urandom);
                do_write(8'($urandom), 4'($urandom),
                         $urandom_range(1, 20), dat, 1'b1);
            end
        end

        // Reset in the middle of a read and a write burst.
        rmode = 0;
        bmode = 0;
        aw_phase(8'h30, 4'd6);
        w_beat(8'h5A, 1'b0, 1'b0);
        w_beat(8'hC3, 1'b0, 1'b0);
        ref_mem[8'h30] = 8'h5A;
        ref_mem[8'h31] = 8'hC3;
        ar_phase(8'h10, 4'd3, 4'd2);
        t = 0;
        while (rq.size() > 2 && t < 20) begin
            @(negedge clk);
            t++;
        end
        #2 rst = 1'b1;
        #1;
        check("rst_read_outputs",
              32'({ARREADY, RVALID, RDATA, RRESP, RLAST}), 0);
        check("rst_write_outputs",
              32'({AWREADY, WREADY, BVALID, BRESP}), 0);
        rq.delete();
        bq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        dat[0] = 8'h3C; dat[1] = 8'h96; dat[2] = 8'h0F;
        fork
            do_read(8'h30, 4'd1, 4'd3);
            do_write(8'h70, 4'd10, 3, dat, 1'b0);
        join
        do_read(8'h70, 4'd2, 4'd4);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- Byte-wide memory slave that sits directly downstream of the bus master and answers its read and write bursts.
- Read path: accepts a read address/length/ID, then streams 1-16 data bytes with a response bit and a last flag.
- Write path: accepts a write address/ID, absorbs data bytes until the last flag, then returns a 5-bit write response.
- Read and write channels are fully independent and may be active at the same time.

Parameters:
- ADDR_W, 8, address width in bits.
- MEM_DEPTH, 256, number of implemented bytes; addresses >= MEM_DEPTH are out of range.
- MAX_BEATS, 16, maximum write beats accepted before the burst is flagged as an error.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ARADDR  in  8  read start address
- ARLEN  in  4  read beats minus 1
- ARID  in  4  read ID (captured only)
- ARVALID  in  1  read address valid
- ARREADY  out  1  read address accepted (1-cycle pulse)
- RVALID  out  1  read data valid
- RREADY  in  1  master ready for read data
- RDATA  out  8  read data byte
- RRESP  out  1  0=OKAY, 1=SLVERR
- RLAST  out  1  final read beat
- AWADDR  in  8  write start address
- AWID  in  4  write ID
- AWVALID  in  1  write address valid
- AWREADY  out  1  write address accepted (1-cycle pulse)
- WDATA  in  8  write data byte
- WLAST  in  1  final write beat
- WVALID  in  1  write data valid
- WREADY  out  1  slave ready for write data
- BVALID  out  1  write response valid
- BREADY  in  1  master ready for response
- BRESP  out  5  {BID[3:0], err}

Behaviour:
- Reset: all outputs 0. Both FSMs go to IDLE. Memory contents are not reset.
- Read FSM states:
  - R_IDLE: if ARVALID=1, capture addr, len and id; go to R_ADDR.
  - R_ADDR: ARREADY=1 for exactly this cycle. Load RDATA=mem[addr], RRESP, and RLAST=(len==0). Go to R_DATA.
  - R_DATA: RVALID=1, ARREADY=0.
- A read beat completes on RVALID&&RREADY:
  - If RLAST: clear RVALID, RLAST, RDATA and RRESP; go to R_IDLE.
  - Otherwise: addr+1 (mod 2^ADDR_W), beat+1, reload RDATA, RRESP and RLAST=(beat+1==len).
  - RDATA, RRESP and RLAST hold steady while RREADY=0.
- Read timing:
  - First RVALID appears 2 cycles after ARVALID is sampled.
  - ARREADY and RVALID are never high together.
  - Back-to-back beats are possible at 1 per cycle.
- Out-of-range read beat (addr >= MEM_DEPTH): RDATA=0, RRESP=1.
- Address wrap: a burst crossing 255 wraps to 0 and continues; this is not an error by itself.
- Write FSM states:
  - W_IDLE: if AWVALID=1, capture addr and id; clear err and beat count; go to W_ADDR.
  - W_ADDR: AWREADY=1 for exactly one cycle. Go to W_DATA.
  - W_DATA: WREADY=1. Each WVALID&&WREADY writes mem[addr]=WDATA (when in range), then addr+1 and beat+1.
- Write error conditions, each setting err:
  - An out-of-range beat; the data is discarded.
  - A beat that arrives after MAX_BEATS beats; the data is discarded.
- Write completion:
  - On an accepted beat with WLAST=1: WREADY=0; go to W_RESP.
  - W_RESP: BVALID=1, BRESP={id, err}. On BREADY=1: BVALID=0, BRESP=0; go to W_IDLE.
- BRESP holds steady while BREADY=0.
- AWREADY and WREADY are never high together.
- No new AR is accepted before the read burst finishes; no new AW is accepted before B is taken.
- Same-cycle read load and write to the same address: the read returns the old byte (read-before-write). The write takes effect for later beats.
- Reset mid-burst: both FSMs go to IDLE immediately and all outputs go to 0. Partially written bytes remain in memory.
- WVALID while not in W_DATA is ignored. RREADY while not in R_DATA is ignored.

Decomposition:
- Shared package axi_mem_pkg:
  - read state encoding R_IDLE/R_ADDR/R_DATA = 0/1/2
  - write state encoding W_IDLE/W_ADDR/W_DATA/W_RESP = 0/1/2/3
  - RESP_OKAY=0, RESP_SLVERR=1
  - MAX_BEATS default
- One sub-module, axi_mem_array: MEM_DEPTH x 8 storage with one synchronous write port and one synchronous read port, read-before-write. Both FSMs stay in the top module.

Test Plan:
- Preload mem[0x10..0x13]=A0..A3; AR addr=0x10, len=3, id=5 with RREADY=1 -> ARREADY pulses once, then 4 consecutive RVALID beats A0,A1,A2,A3 with RRESP=0 and RLAST only on A3.
- AW addr=0x20, id=9; WDATA 11,22 with WLAST on 22; BREADY=1 -> BRESP=5'b10010 for one cycle; a read of 0x20 len=1 then returns 11,22.
- Read len=15 with RREADY toggling 1-0-1 -> no beat lost or duplicated, RDATA stable while RREADY=0, 16 beats total.
- MEM_DEPTH=128; AR addr=0x7F, len=1 -> beat0=mem[0x7F] with RRESP=0, beat1 RDATA=0 with RRESP=1. Write to 0x80 with id=3 -> BRESP=5'b00111 and memory unchanged.
- 17 write beats without WLAST, then WLAST on the 18th -> first 16 bytes stored, BRESP err=1. AR and AW issued in the same cycle -> both channels complete correctly.
- Assert rst during the read beat 2 of 4 and during W_DATA -> all outputs 0 at once; afterwards a fresh AR/AW pair completes normally.
